// File: rtl/shift_reg_pkg.sv
// Shared definitions for the shift-register family: PISO state encoding and
// the helper that sizes bit counters from a word width.
package shift_reg_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    // Width of a counter that indexes every bit of a word; never below 1 bit.
    function automatic int bit_cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter. A word accepted over load_valid/load_ready
// is shifted out one bit per serial beat (serial_valid & serial_ready), with
// frame_start/frame_end marking the first and last bit. A word offered while
// the last bit is being accepted is loaded on the same edge, so back-to-back
// words stream with no idle gap.
module piso_serializer
    import shift_reg_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] parallel_in,
    input  logic                  load_valid,
    output logic                  load_ready,
    output logic                  serial_out,
    output logic                  serial_valid,
    input  logic                  serial_ready,
    output logic                  frame_start,
    output logic                  frame_end,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  frames_sent
);

    localparam int             BW       = bit_cnt_width(DATA_WIDTH);
    localparam logic [BW-1:0]  LAST_BIT = BW'(DATA_WIDTH - 1);

    if (DATA_WIDTH < 2) begin : g_width_check
        $error("piso_serializer: DATA_WIDTH must be at least 2");
    end

    piso_state_t           state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [BW-1:0]         bit_cnt;
    logic                  beat;
    logic                  last_bit;

    // Outputs are decoded from registered state only, except load_ready which
    // must also open on the final beat to allow zero-gap reload.
    always_comb begin
        busy         = (state == SHIFT);
        serial_valid = busy;
        serial_out   = MSB_FIRST ? shift_reg[DATA_WIDTH-1] : shift_reg[0];
        last_bit     = (bit_cnt == LAST_BIT);
        frame_start  = busy & (bit_cnt == '0);
        frame_end    = busy & last_bit;
        beat         = serial_valid & serial_ready;
        load_ready   = (state == IDLE) | (frame_end & serial_ready);
    end

    // Control FSM, shifter, bit counter and frame counter in one sequential block.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            // NOTE: shift_reg is cleared on reset (not left unknown) because
            // serial_out is decoded straight from it and must read 0 out of reset.
            state       <= IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            frames_sent <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        shift_reg <= parallel_in;
                        bit_cnt   <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (beat) begin
                        if (last_bit) begin
                            frames_sent <= frames_sent + CNT_WIDTH'(1);
                            if (load_valid) begin
                                shift_reg <= parallel_in;
                                bit_cnt   <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            if (MSB_FIRST) begin
                                shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
                            end else begin
                                shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
                            end
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A presented bit must stay put, and stay valid, until the sink takes it.
    a_hold_until_beat : assert property (
        @(posedge clk) disable iff (reset)
        (serial_valid && !serial_ready) |=> (serial_valid && $stable(serial_out))
    );

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer. Directed words push their expected bit
// stream (written out by hand in transmission order, first bit in [15]) into a
// queue; negedge monitors pop and compare on every serial beat.
module tb_piso_serializer;

    typedef struct packed {
        logic b;
        logic fs;
        logic fe;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;

    // MSB-first instance
    logic [15:0] parallel_in_m;
    logic        load_valid_m, load_ready_m;
    logic        serial_out_m, serial_valid_m, serial_ready_m;
    logic        frame_start_m, frame_end_m, busy_m;
    logic [15:0] frames_sent_m;

    // LSB-first instance
    logic [15:0] parallel_in_l;
    logic        load_valid_l, load_ready_l;
    logic        serial_out_l, serial_valid_l, serial_ready_l;
    logic        frame_start_l, frame_end_l, busy_l;
    logic [15:0] frames_sent_l;

    int    tests_run    = 0;
    int    tests_failed = 0;
    int    exp_frames_m = 0;
    int    cycles;
    beat_t q_m[$];
    beat_t q_l[$];
    beat_t e_m, e_l;
    logic  prev_stall_m = 1'b0;
    logic  prev_bit_m   = 1'b0;

    piso_serializer #(.DATA_WIDTH(16), .MSB_FIRST(1'b1), .CNT_WIDTH(16)) dut_m (
        .clk(clk), .reset(reset),
        .parallel_in(parallel_in_m), .load_valid(load_valid_m), .load_ready(load_ready_m),
        .serial_out(serial_out_m), .serial_valid(serial_valid_m), .serial_ready(serial_ready_m),
        .frame_start(frame_start_m), .frame_end(frame_end_m), .busy(busy_m),
        .frames_sent(frames_sent_m)
    );

    piso_serializer #(.DATA_WIDTH(16), .MSB_FIRST(1'b0), .CNT_WIDTH(16)) dut_l (
        .clk(clk), .reset(reset),
        .parallel_in(parallel_in_l), .load_valid(load_valid_l), .load_ready(load_ready_l),
        .serial_out(serial_out_l), .serial_valid(serial_valid_l), .serial_ready(serial_ready_l),
        .frame_start(frame_start_l), .frame_end(frame_end_l), .busy(busy_l),
        .frames_sent(frames_sent_l)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // seq holds the bits in transmission order, first bit in seq[15].
    task automatic push_seq(input logic [15:0] seq, input int n, input bit to_lsb_dut);
        beat_t e;
        for (int i = 0; i < n; i++) begin
            e.b  = seq[15-i];
            e.fs = (i == 0);
            e.fe = (i == 15);
            if (to_lsb_dut) q_l.push_back(e);
            else            q_m.push_back(e);
        end
    endtask

    // Called just after a rising edge with the MSB-first instance idle.
    task automatic load_m(input logic [15:0] data);
        load_valid_m  = 1'b1;
        parallel_in_m = data;
        @(posedge clk); #1;
        load_valid_m  = 1'b0;
        check("latency1_busy", busy_m, 1);
        check("latency1_frame_start", frame_start_m, 1);
    endtask

    // Advance edge by edge until the chosen instance goes idle, bounded.
    task automatic run_until_idle(input bit lsb, inout int n);
        while ((lsb ? busy_l : busy_m) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("idle_timeout", 1, 0);
    endtask

    // Monitor for the MSB-first instance: stall stability and scoreboard pop.
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_stall_m) begin
                check("stall_hold_bit", serial_out_m, prev_bit_m);
                check("stall_hold_valid", serial_valid_m, 1);
            end
            if (serial_valid_m && serial_ready_m) begin
                if (q_m.size() == 0) begin
                    check("m_unexpected_beat", 1, 0);
                end else begin
                    e_m = q_m.pop_front();
                    check("m_bit", serial_out_m, e_m.b);
                    check("m_frame_start", frame_start_m, e_m.fs);
                    check("m_frame_end", frame_end_m, e_m.fe);
                    check("m_load_ready", load_ready_m, e_m.fe);
                end
            end else if (!serial_valid_m) begin
                check("m_idle_load_ready", load_ready_m, 1);
                check("m_idle_flags", {frame_start_m, frame_end_m}, 0);
            end
        end
        prev_stall_m = !reset && serial_valid_m && !serial_ready_m;
        prev_bit_m   = serial_out_m;
    end

    // Monitor for the LSB-first instance.
    always @(negedge clk) begin
        if (!reset && serial_valid_l && serial_ready_l) begin
            if (q_l.size() == 0) begin
                check("l_unexpected_beat", 1, 0);
            end else begin
                e_l = q_l.pop_front();
                check("l_bit", serial_out_l, e_l.b);
                check("l_frame_start", frame_start_l, e_l.fs);
                check("l_frame_end", frame_end_l, e_l.fe);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // NOTE: stimulus is driven with blocking assignments 1 time unit after
        // the rising edge, so the DUT always samples settled values.
        reset          = 1'b1;
        parallel_in_m  = '0; load_valid_m = 1'b0; serial_ready_m = 1'b1;
        parallel_in_l  = '0; load_valid_l = 1'b0; serial_ready_l = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset values
        check("rst_busy", busy_m, 0);
        check("rst_serial_valid", serial_valid_m, 0);
        check("rst_serial_out", serial_out_m, 0);
        check("rst_frame_flags", {frame_start_m, frame_end_m}, 0);
        check("rst_load_ready", load_ready_m, 1);
        check("rst_frames_sent", frames_sent_m, 0);
        check("rst_frames_sent_l", frames_sent_l, 0);

        // MSB-first A5C3: 1010_0101_1100_0011 in 16 cycles
        push_seq(16'hA5C3, 16, 1'b0);
        load_m(16'hA5C3);
        cycles = 0;
        run_until_idle(1'b0, cycles);
        exp_frames_m++;
        check("a5c3_cycles", cycles, 16);
        check("a5c3_frames_sent", frames_sent_m, exp_frames_m);

        // LSB-first 0001: a one then fifteen zeros
        push_seq(16'h8000, 16, 1'b1);
        load_valid_l  = 1'b1;
        parallel_in_l = 16'h0001;
        @(posedge clk); #1;
        load_valid_l  = 1'b0;
        cycles = 0;
        run_until_idle(1'b1, cycles);
        check("lsb_cycles", cycles, 16);
        check("lsb_frames_sent", frames_sent_l, 1);

        // Zero-gap stream: FFFF then 0000 with load_valid held; the data change
        // mid-word must not disturb the word in flight.
        push_seq(16'hFFFF, 16, 1'b0);
        push_seq(16'h0000, 16, 1'b0);
        load_valid_m  = 1'b1;
        parallel_in_m = 16'hFFFF;
        @(posedge clk); #1;
        parallel_in_m = 16'h0000;
        cycles = 0;
        repeat (16) begin
            @(posedge clk); #1;
            cycles++;
        end
        load_valid_m = 1'b0;
        check("stream_still_busy", busy_m, 1);
        check("stream_second_frame_start", frame_start_m, 1);
        run_until_idle(1'b0, cycles);
        exp_frames_m += 2;
        check("stream_cycles", cycles, 32);
        check("stream_frames_sent", frames_sent_m, exp_frames_m);

        // Stalled A5C3: each bit is held one cycle, then accepted
        push_seq(16'hA5C3, 16, 1'b0);
        load_m(16'hA5C3);
        serial_ready_m = 1'b0;
        cycles = 0;
        while (busy_m && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
            serial_ready_m = ~serial_ready_m;
        end
        serial_ready_m = 1'b1;
        exp_frames_m++;
        check("stall_cycles", cycles, 32);
        check("stall_frames_sent", frames_sent_m, exp_frames_m);

        // Reset after 5 bits of BEEF (1011_1...), then a clean 1234
        push_seq(16'hBEEF, 5, 1'b0);
        load_m(16'hBEEF);
        repeat (5) @(posedge clk);
        #1;
        reset          = 1'b1;
        serial_ready_m = 1'b0;
        @(posedge clk); #1;
        reset          = 1'b0;
        serial_ready_m = 1'b1;
        check("midrst_busy", busy_m, 0);
        check("midrst_serial_valid", serial_valid_m, 0);
        check("midrst_load_ready", load_ready_m, 1);
        check("midrst_frames_sent", frames_sent_m, 0);
        check("midrst_bits_consumed", q_m.size(), 0);
        exp_frames_m = 0;

        push_seq(16'h1234, 16, 1'b0);
        load_m(16'h1234);
        cycles = 0;
        run_until_idle(1'b0, cycles);
        exp_frames_m++;
        check("post_rst_cycles", cycles, 16);
        check("post_rst_frames_sent", frames_sent_m, exp_frames_m);

        @(posedge clk); #1;
        check("scoreboard_m_empty", q_m.size(), 0);
        check("scoreboard_l_empty", q_l.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
